coreaxitoahbl_ram_rd_ctrl: RTL and testbench



---
 rtl/coreaxitoahbl_pkg.sv | 31 +++
 rtl/coreaxitoahbl_gray_sync.sv | 29 ++
 rtl/coreaxitoahbl_ram_rd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_coreaxitoahbl_ram_rd_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coreaxitoahbl_pkg.sv
// Shared definitions for the AXI-to-AHB-Lite bridge burst RAM: pointer width,
// read-controller state encoding and Gray/binary pointer conversion.
package coreaxitoahbl_pkg;

  // Widest pointer supported (AXI_LWIDTH up to 8, plus the wrap bit).
  localparam int unsigned PTR_W_MAX = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rdState_t;

  function automatic int unsigned ptrWidth(input int unsigned lWidth);
    return lWidth + 1;
  endfunction

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b = g;
    for (int unsigned i = 1; i < PTR_W_MAX; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/coreaxitoahbl_gray_sync.sv
// Two-flop synchronizer for a Gray-coded pointer, followed by conversion
// back to binary in the destination domain.
module coreaxitoahbl_gray_sync
  import coreaxitoahbl_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] grayIn,
  output logic [WIDTH-1:0] binOut
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= grayIn;
      sync <= meta;
    end
  end

  assign binOut = WIDTH'(gray2bin(PTR_W_MAX'(sync)));

endmodule

// File: rtl/coreaxitoahbl_ram_rd_ctrl.sv
// Read-side controller of the dual-clock burst RAM: streams commanded bursts
// out of the RAM over valid/ready and returns its Gray read pointer.
module coreaxitoahbl_ram_rd_ctrl
  import coreaxitoahbl_pkg::*;
#(
  parameter int unsigned AXI_DWIDTH = 64,
  parameter int unsigned AXI_LWIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  rdCLK,
  input  logic                  RESETN,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic [LEN_WIDTH-1:0]  cmdLen,
  input  logic [AXI_LWIDTH:0]   wrPtrGray,
  output logic [AXI_LWIDTH:0]   rdPtrGray,
  output logic [AXI_LWIDTH-1:0] rdAddr,
  input  logic [AXI_DWIDTH-1:0] rdData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [AXI_DWIDTH-1:0] outData,
  output logic                  outLast,
  output logic                  done
);

  localparam int unsigned PW = ptrWidth(AXI_LWIDTH);

  rdState_t             state;
  rdState_t             nextState;
  logic [PW-1:0]        rdPtr;
  logic [PW-1:0]        wrPtrSync;
  logic [LEN_WIDTH:0]   issueLeft;
  logic                 inFlight;
  logic                 inFlightLast;
  logic [1:0]           bufCnt;
  logic [AXI_DWIDTH-1:0] bufData0;
  logic [AXI_DWIDTH-1:0] bufData1;
  logic                 bufLast0;
  logic                 bufLast1;
  logic [2:0]           occupancy;
  logic                 empty;
  logic                 pop;
  logic                 issue;
  logic                 cmdFire;
  logic                 lastPop;

  coreaxitoahbl_gray_sync #(
    .WIDTH(PW)
  ) u_wrPtrSync (
    .clk   (rdCLK),
    .RESETN(RESETN),
    .grayIn(wrPtrGray),
    .binOut(wrPtrSync)
  );

  // Full-width compare: equal low bits with differing MSB means a full RAM.
  assign empty    = (wrPtrSync == rdPtr);
  assign rdAddr   = rdPtr[AXI_LWIDTH-1:0];
  assign outValid = (bufCnt != 2'd0);
  assign outData  = bufData0;
  assign outLast  = bufLast0;
  assign pop      = outValid && outReady;
  assign cmdFire  = cmdValid && cmdReady;
  assign lastPop  = pop && outLast;

  // Buffer slots already committed, including the read still in the RAM.
  assign occupancy = {1'b0, bufCnt} + {2'b00, inFlight};
  assign issue = (state == READ) && !empty && (issueLeft != '0) &&
                 (occupancy < (3'd2 + {2'b00, pop}));

  always_comb begin
    nextState = state;
    cmdReady  = 1'b0;
    case (state)
      IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) nextState = READ;
      end
      READ: begin
        if (issue && (issueLeft == (LEN_WIDTH+1)'(1))) nextState = DRAIN;
      end
      DRAIN: begin
        if (lastPop) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge rdCLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= nextState;
      done  <= (state == DRAIN) && lastPop;
    end
  end

  always_ff @(posedge rdCLK or negedge RESETN) begin
    if (!RESETN) begin
      rdPtr        <= '0;
      rdPtrGray    <= '0;
      issueLeft    <= '0;
      inFlight     <= 1'b0;
      inFlightLast <= 1'b0;
    end else begin
      rdPtrGray <= PW'(bin2gray(PTR_W_MAX'(rdPtr)));
      inFlight  <= issue;
      if (cmdFire) begin
        issueLeft <= {1'b0, cmdLen} + (LEN_WIDTH+1)'(1);
      end else if (issue) begin
        issueLeft <= issueLeft - (LEN_WIDTH+1)'(1);
      end
      if (issue) begin
        rdPtr        <= rdPtr + PW'(1);
        inFlightLast <= (issueLeft == (LEN_WIDTH+1)'(1));
      end
    end
  end

  // Slot 0 is always the head; a pop shifts slot 1 forward.
  always_ff @(posedge rdCLK or negedge RESETN) begin
    if (!RESETN) begin
      bufCnt   <= '0;
      bufData0 <= '0;
      bufData1 <= '0;
      bufLast0 <= 1'b0;
      bufLast1 <= 1'b0;
    end else begin
      case ({inFlight, pop})
        2'b10: begin
          if (bufCnt == 2'd0) begin
            bufData0 <= rdData;
            bufLast0 <= inFlightLast;
          end else begin
            bufData1 <= rdData;
            bufLast1 <= inFlightLast;
          end
          bufCnt <= bufCnt + 2'd1;
        end
        2'b01: begin
          bufData0 <= bufData1;
          bufLast0 <= bufLast1;
          bufCnt   <= bufCnt - 2'd1;
        end
        2'b11: begin
          if (bufCnt == 2'd1) begin
            bufData0 <= rdData;
            bufLast0 <= inFlightLast;
          end else begin
            bufData0 <= bufData1;
            bufLast0 <= bufLast1;
            bufData1 <= rdData;
            bufLast1 <= inFlightLast;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coreaxitoahbl_ram_rd_ctrl.sv
// Bench for the burst RAM read controller: behavioural RAM and writer,
// a word-stream reference model and a decoupled output scoreboard.
module tb_coreaxitoahbl_ram_rd_ctrl;

  localparam int unsigned DW    = 64;
  localparam int unsigned LW    = 4;
  localparam int unsigned LENW  = 8;
  localparam int unsigned PW    = LW + 1;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NWORDS = 2048;

  logic            rdCLK = 1'b0;
  logic            RESETN = 1'b0;
  logic            cmdValid = 1'b0;
  logic            cmdReady;
  logic [LENW-1:0] cmdLen = '0;
  logic [PW-1:0]   wrPtrGray = '0;
  logic [PW-1:0]   rdPtrGray;
  logic [LW-1:0]   rdAddr;
  logic [DW-1:0]   rdData = '0;
  logic            outValid;
  logic            outReady = 1'b1;
  logic [DW-1:0]   outData;
  logic            outLast;
  logic            done;

  coreaxitoahbl_ram_rd_ctrl #(
    .AXI_DWIDTH(DW),
    .AXI_LWIDTH(LW),
    .LEN_WIDTH (LENW)
  ) dut (
    .rdCLK    (rdCLK),
    .RESETN   (RESETN),
    .cmdValid (cmdValid),
    .cmdReady (cmdReady),
    .cmdLen   (cmdLen),
    .wrPtrGray(wrPtrGray),
    .rdPtrGray(rdPtrGray),
    .rdAddr   (rdAddr),
    .rdData   (rdData),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .outLast  (outLast),
    .done     (done)
  );

  always #5 rdCLK = ~rdCLK;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned cmdNegCyc = 0;
  int unsigned wrIdx = 0;
  int unsigned wrLimit = 0;
  int unsigned rdIdx = 0;
  int unsigned streamBase = 0;
  int unsigned readyMode = 0;
  logic [PW-1:0] wrPtr = '0;
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] dataStream [NWORDS];
  beat_t expQ[$];

  beat_t         monBeat;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;
  logic          prevLast = 1'b0;
  logic          expDone = 1'b0;

  function automatic logic [PW-1:0] toGray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] fromGray(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    logic acc;
    acc = 1'b0;
    b = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      acc = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] modelPtr();
    return PW'(rdIdx - streamBase);
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge rdCLK) cyc++;

  // Synchronous-read RAM: data appears the cycle after the address.
  always @(posedge rdCLK) rdData <= ram[rdAddr];

  // Write side: fills the RAM with the next words of the stream while space remains.
  always @(posedge rdCLK) begin
    #2;
    if (!RESETN) begin
      wrPtr     = '0;
      wrPtrGray = '0;
    end else if (wrIdx < wrLimit && ((wrPtr - fromGray(rdPtrGray)) < PW'(DEPTH))) begin
      ram[wrPtr[LW-1:0]] = dataStream[wrIdx];
      wrIdx++;
      wrPtr     = wrPtr + 1'b1;
      wrPtrGray = toGray(wrPtr);
    end
  end

  always @(posedge rdCLK) begin
    #2;
    case (readyMode)
      0: outReady = 1'b1;
      1: outReady = !outReady;
      default: outReady = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard monitor: every accepted beat is compared with the model's next entry.
  always @(negedge rdCLK) begin
    if (!RESETN) begin
      prevStall = 1'b0;
      expDone   = 1'b0;
    end else begin
      if (done || expDone) checkVal("donePulse", {62'd0, cmdReady, done}, {62'd0, 1'b1, expDone});
      expDone = 1'b0;
      if (prevStall) checkVal("stallStable", {outValid, outLast, outData[61:0]},
                              {1'b1, prevLast, prevData[61:0]});
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedBeat: got data 0x%0h with no beat expected at cycle %0d", outData, cyc);
        end else begin
          monBeat = expQ.pop_front();
          checkVal("beatData", outData, monBeat.data);
          checkVal("beatLast", {63'd0, outLast}, {63'd0, monBeat.last});
          if (monBeat.last) expDone = 1'b1;
        end
      end
      prevStall = outValid && !outReady;
      prevData  = outData;
      prevLast  = outLast;
    end
  end

  task automatic waitCycles(input int unsigned n);
    repeat (n) @(negedge rdCLK);
  endtask

  task automatic sendCmd(input int unsigned len);
    bit ok;
    @(posedge rdCLK);
    #2;
    cmdValid = 1'b1;
    cmdLen   = LENW'(len);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge rdCLK);
      if (cmdReady) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmdTimeout: cmdReady stayed 0, required 1");
    end else begin
      cmdNegCyc = cyc;
      for (int unsigned j = 0; j <= len; j++) begin
        expQ.push_back('{data: dataStream[rdIdx], last: (j == len)});
        rdIdx++;
      end
    end
    @(posedge rdCLK);
    #2;
    cmdValid = 1'b0;
  endtask

  task automatic waitQSize(input int unsigned n, input int unsigned bound);
    for (int unsigned k = 0; k < bound && expQ.size() > n; k++) @(negedge rdCLK);
    checkVal("queueProgress", expQ.size(), n);
  endtask

  task automatic waitDrain(input int unsigned bound);
    waitQSize(0, bound);
    waitCycles(3);
  endtask

  task automatic measureBurst(output int unsigned firstLat, output int unsigned span);
    int unsigned firstCyc;
    int unsigned k;
    k = 0;
    do begin
      @(negedge rdCLK);
      k++;
    end while (!outValid && k < 50);
    firstLat = cyc - cmdNegCyc;
    firstCyc = cyc;
    k = 0;
    while (!(outValid && outReady && outLast) && k < 100) begin
      @(negedge rdCLK);
      k++;
    end
    span = cyc - firstCyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    int unsigned span;
    bit sawValid;
    int unsigned len;

    for (int i = 0; i < int'(NWORDS); i++) dataStream[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) dataStream[i] = 64'hA0 + 64'(i);

    #1;
    checkVal("resetOutputs", {58'd0, cmdReady, outValid, outLast, done, |outData, |rdAddr},
             {58'd0, 1'b1, 5'b0});
    checkVal("resetPtrGray", rdPtrGray, 0);
    repeat (3) @(posedge rdCLK);
    #4 RESETN = 1'b1;
    @(negedge rdCLK);
    checkVal("postResetReady", cmdReady, 1);

    // Basic burst with four preloaded words.
    readyMode = 0;
    wrLimit = 4;
    waitCycles(8);
    sendCmd(3);
    measureBurst(lat, span);
    checkVal("basicFirstLatency", lat, 3);
    checkVal("basicSpan", span, 3);
    waitDrain(50);
    checkVal("basicPtrGray", rdPtrGray, toGray(modelPtr()));
    checkVal("basicPtrGraySix", rdPtrGray, 6);

    // Burst of 8 with only 4 words written: must stall until the writer advances.
    wrLimit = wrIdx + 4;
    waitCycles(8);
    sendCmd(7);
    waitQSize(4, 100);
    sawValid = 1'b0;
    repeat (8) begin
      @(negedge rdCLK);
      if (outValid) sawValid = 1'b1;
    end
    checkVal("stallValidLow", sawValid, 0);
    wrLimit = wrIdx + 4;
    waitDrain(100);
    checkVal("stallPtrGray", rdPtrGray, toGray(modelPtr()));

    // Wrap: read pointer at 12, RAM full (MSB differs), 24 beats without a bubble.
    wrLimit = wrIdx + 24;
    waitCycles(24);
    sendCmd(23);
    measureBurst(lat, span);
    checkVal("wrapFirstLatency", lat, 3);
    checkVal("wrapSpan", span, 23);
    waitDrain(100);
    checkVal("wrapPtrGray", rdPtrGray, toGray(modelPtr()));
    checkVal("wrapRdAddr", rdAddr, 64'(modelPtr() % DEPTH));

    // Alternating backpressure.
    readyMode = 1;
    wrLimit = wrIdx + 10;
    sendCmd(9);
    waitDrain(200);
    checkVal("bpPtrGray", rdPtrGray, toGray(modelPtr()));

    // Random bursts under random backpressure.
    readyMode = 2;
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(0, 40);
      wrLimit = wrIdx + len + 1;
      sendCmd(len);
      waitDrain(800);
      checkVal("randPtrGray", rdPtrGray, toGray(modelPtr()));
    end

    // Reset in the middle of an 8-beat burst.
    readyMode = 0;
    wrLimit = wrIdx + 8;
    waitCycles(12);
    sendCmd(7);
    waitQSize(5, 100);
    #3 RESETN = 1'b0;
    #1;
    checkVal("midResetOutputs", {58'd0, cmdReady, outValid, outLast, done, |outData, |rdAddr},
             {58'd0, 1'b1, 5'b0});
    checkVal("midResetPtrGray", rdPtrGray, 0);
    wrLimit = wrIdx;
    expQ.delete();
    rdIdx = wrIdx;
    streamBase = wrIdx;
    repeat (2) @(posedge rdCLK);
    #4 RESETN = 1'b1;
    @(negedge rdCLK);
    checkVal("midResetReady", {62'd0, cmdReady, outValid}, {62'd0, 1'b1, 1'b0});

    wrLimit = wrIdx + 1;
    waitCycles(6);
    sendCmd(0);
    waitDrain(50);
    checkVal("singlePtrGray", rdPtrGray, toGray(modelPtr()));

    waitCycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
